pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central stall/flush/forward controller for the 5-stage pipeline.
- Drives the enable and NOP controls of the PC, IF/ID and ID/EX registers: `hazard_stall_n`, `mem_stall_n`, `take_new_PC`, and the `ex_fwd_*`/`mem_fwd_*` selects.
- Sequences multi-cycle instruction-memory and data-memory waits, holds a branch redirect that arrives during a wait, and latches halt.
- Sits beside the decode stage; watches the ID, ID/EX and EX/MEM register contents.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  3  Rs of the instruction in ID
- id_rt  in  3  Rt of the instruction in ID
- id_rs_used  in  1  ID instruction reads Rs
- id_rt_used  in  1  ID instruction reads Rt
- ex_wr_en  in  1  ID/EX output wr_en
- ex_wr_reg  in  3  ID/EX output wr_reg
- ex_is_load  in  1  ID/EX output mem_en & ~mem_wr
- mem_wr_en  in  1  EX/MEM output wr_en
- mem_wr_reg  in  3  EX/MEM output wr_reg
- redirect  in  1  branch/jump resolved taken in EX
- imem_busy  in  1  instruction memory has not delivered this cycle
- dmem_busy  in  1  data memory access in progress
- wb_halt  in  1  halt has reached MEM/WB
- pc_en  out  1  PC write enable
- if_id_en  out  1  IF/ID write enable
- if_id_flush  out  1  load NOP into IF/ID
- hazard_stall_n  out  1  0 = inject bubble into ID/EX
- mem_stall_n  out  1  0 = freeze every pipe register
- take_new_PC  out  1  flush IF/ID and ID/EX, PC loads target
- ex_fwd_Rs, ex_fwd_Rt  out  1 each  forward from EX
- mem_fwd_Rs, mem_fwd_Rt  out  1 each  forward from MEM
- halted  out  1  processor halted
- state  out  3  current FSM state, for debug
- stall_cnt  out  CNT_W  stall cycles since reset, saturating

Behaviour:
- Async reset (rst_n=0) clears: state=RUN, redir_pend=0, halted=0, stall_cnt=0.
- During reset the outputs take these values: pc_en=1, if_id_en=1, if_id_flush=0, hazard_stall_n=1, mem_stall_n=1, take_new_PC=0. Forward outputs stay combinational.
- Forwarding is combinational and independent of state:
  - ex_fwd_Rs = id_rs_used & ex_wr_en & ~ex_is_load & (ex_wr_reg==id_rs).
  - mem_fwd_Rs = id_rs_used & mem_wr_en & (mem_wr_reg==id_rs) & ~ex_fwd_Rs.
  - The Rt versions are the same with id_rt / id_rt_used.
- Load-use: ld_use = ex_is_load & ex_wr_en & ((id_rs_used & ex_wr_reg==id_rs) | (id_rt_used & ex_wr_reg==id_rt)).
- FSM states are RUN, LD_STALL, DMEM_WAIT, IMEM_WAIT, HALTED (encoding lives in the package).
- Next-state priority in every non-HALTED state: wb_halt > dmem_busy > imem_busy > ld_use > RUN.
- RUN, LD_STALL:
  - All enables are 1 unless a redirect or load-use applies.
  - redirect=1: take_new_PC=1, if_id_flush=1, hazard_stall_n=0.
  - ld_use=1 and no redirect: pc_en=0, if_id_en=0, hazard_stall_n=0. Go to LD_STALL for exactly that cycle. The load advances, so the next cycle resolves through mem_fwd.
  - redirect overrides ld_use in the same cycle.
- DMEM_WAIT:
  - mem_stall_n=0, pc_en=0, if_id_en=0; all other controls hold their RUN values.
  - A redirect seen here sets redir_pend.
  - Stay while dmem_busy. On the first cycle with dmem_busy=0, mem_stall_n=1 and normal RUN rules apply.
- IMEM_WAIT:
  - pc_en=0, if_id_en=0, if_id_flush=1 (bubble into IF/ID); the back end keeps running.
  - A redirect here sets redir_pend and is not acted on.
  - On imem_busy=0 with redir_pend=1: assert take_new_PC=1, if_id_flush=1, hazard_stall_n=0 for one cycle, then clear redir_pend.
- redir_pend is only cleared when take_new_PC is issued. redirect and a pending redirect together issue a single take_new_PC.
- HALTED:
  - Entered on wb_halt; sets halted=1.
  - pc_en=0, if_id_en=0, hazard_stall_n=0, mem_stall_n=1. Holds until reset.
  - wb_halt while dmem_busy: wait until dmem_busy=0, then enter HALTED.
- stall_cnt: +1 on each clock edge where pc_en=0 and state!=HALTED. Saturates at all-ones; no wrap.

Decomposition:
- pipe_ctrl_pkg:
  - state encoding constants (RUN=0, LD_STALL=1, DMEM_WAIT=2, IMEM_WAIT=3, HALTED=4);
  - REG_W=3.
- Sub-module fwd_unit: pure combinational forwarding and load-use detect, instantiated once.
- FSM, redirect latch and counter stay in pipe_ctrl; registers use the team `register` cell with async active-low reset.

Test Plan:
- Reset mid-DMEM_WAIT (rst_n=0 while dmem_busy=1) -> state=0, stall_cnt=0, mem_stall_n=1 immediately, asynchronously.
- ex_wr_en=1, ex_wr_reg=3, ex_is_load=0, id_rs=3, id_rs_used=1, mem_wr_reg=3, mem_wr_en=1 -> ex_fwd_Rs=1, mem_fwd_Rs=0.
- Same but ex_is_load=1 -> one cycle of pc_en=0, if_id_en=0, hazard_stall_n=0, state=1. Next cycle with mem_wr_reg=3 -> mem_fwd_Rs=1, pc_en=1; stall_cnt=1.
- dmem_busy high 4 cycles -> mem_stall_n=0 for 4 cycles, state=2, stall_cnt +4.
- imem_busy high 3 cycles with redirect pulsed in cycle 2 -> no take_new_PC during wait; take_new_PC=1 for exactly one cycle after imem_busy falls.
- wb_halt=1 -> halted=1, pc_en=0 held for 10+ cycles, stall_cnt frozen.
- Force stall_cnt near all-ones (CNT_W=4) with 20 stall cycles -> stall_cnt=15, no wrap.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush/forward controller:
// register-index width and the controller FSM encoding.
package pipe_ctrl_pkg;

  localparam int REG_W = 3;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_LD_STALL  = 3'd1,
    ST_DMEM_WAIT = 3'd2,
    ST_IMEM_WAIT = 3'd3,
    ST_HALTED    = 3'd4
  } state_e;

endpackage

// File: rtl/pipe_ctrl_fwd_unit.sv
// Combinational operand forwarding selects and load-use hazard detection
// for the instruction sitting in ID.
module pipe_ctrl_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             ex_wr_en,
  input  logic [REG_W-1:0] ex_wr_reg,
  input  logic             ex_is_load,
  input  logic             mem_wr_en,
  input  logic [REG_W-1:0] mem_wr_reg,
  output logic             ex_fwd_rs,
  output logic             ex_fwd_rt,
  output logic             mem_fwd_rs,
  output logic             mem_fwd_rt,
  output logic             ld_use
);

  logic ex_hit_rs, ex_hit_rt;

  assign ex_hit_rs = id_rs_used & ex_wr_en & (ex_wr_reg == id_rs);
  assign ex_hit_rt = id_rt_used & ex_wr_en & (ex_wr_reg == id_rt);

  // A load in EX has no data yet, so it can never be the forwarding source.
  assign ex_fwd_rs = ex_hit_rs & ~ex_is_load;
  assign ex_fwd_rt = ex_hit_rt & ~ex_is_load;

  // The younger EX result wins over the older MEM result.
  assign mem_fwd_rs = id_rs_used & mem_wr_en & (mem_wr_reg == id_rs) & ~ex_fwd_rs;
  assign mem_fwd_rt = id_rt_used & mem_wr_en & (mem_wr_reg == id_rt) & ~ex_fwd_rt;

  assign ld_use = ex_is_load & (ex_hit_rs | ex_hit_rt);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline: memory-wait
// sequencing, deferred branch redirect, halt latch and stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             ex_wr_en,
  input  logic [REG_W-1:0] ex_wr_reg,
  input  logic             ex_is_load,
  input  logic             mem_wr_en,
  input  logic [REG_W-1:0] mem_wr_reg,
  input  logic             redirect,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             hazard_stall_n,
  output logic             mem_stall_n,
  output logic             take_new_PC,
  output logic             ex_fwd_Rs,
  output logic             ex_fwd_Rt,
  output logic             mem_fwd_Rs,
  output logic             mem_fwd_Rt,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e           state_q, state_d;
  logic             redir_pend_q, redir_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             ld_use;

  pipe_ctrl_fwd_unit u_fwd_unit (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .ex_wr_en   (ex_wr_en),
    .ex_wr_reg  (ex_wr_reg),
    .ex_is_load (ex_is_load),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_reg (mem_wr_reg),
    .ex_fwd_rs  (ex_fwd_Rs),
    .ex_fwd_rt  (ex_fwd_Rt),
    .mem_fwd_rs (mem_fwd_Rs),
    .mem_fwd_rt (mem_fwd_Rt),
    .ld_use     (ld_use)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      redir_pend_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      redir_pend_q <= redir_pend_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // A busy memory freezes the pipe in the very cycle it reports busy; the
  // wait states record that for debug and for halt sequencing.
  always_comb begin
    pc_en          = 1'b1;
    if_id_en       = 1'b1;
    if_id_flush    = 1'b0;
    hazard_stall_n = 1'b1;
    mem_stall_n    = 1'b1;
    take_new_PC    = 1'b0;
    if (!rst_n) begin
      // reset values are the defaults above
    end else if (state_q == ST_HALTED) begin
      pc_en          = 1'b0;
      if_id_en       = 1'b0;
      hazard_stall_n = 1'b0;
    end else if (dmem_busy) begin
      mem_stall_n = 1'b0;
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
    end else if (imem_busy) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
    end else if (redirect || redir_pend_q) begin
      take_new_PC    = 1'b1;
      if_id_flush    = 1'b1;
      hazard_stall_n = 1'b0;
    end else if (ld_use) begin
      pc_en          = 1'b0;
      if_id_en       = 1'b0;
      hazard_stall_n = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q != ST_HALTED) begin
      if (wb_halt && !dmem_busy)              state_d = ST_HALTED;
      else if (dmem_busy)                     state_d = ST_DMEM_WAIT;
      else if (imem_busy)                     state_d = ST_IMEM_WAIT;
      else if (ld_use && !take_new_PC)        state_d = ST_LD_STALL;
      else                                    state_d = ST_RUN;
    end
  end

  // A redirect that cannot be acted on is remembered until it is issued.
  assign redir_pend_d = (redir_pend_q | redirect) & ~take_new_PC;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && state_q != ST_HALTED && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign halted    = (state_q == ST_HALTED);
  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected values are queued as stimulus is
// applied and compared against the DUT once its outputs have settled.
module tb_pipe_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       id_rs, id_rt, ex_wr_reg, mem_wr_reg;
  logic             id_rs_used, id_rt_used, ex_wr_en, ex_is_load, mem_wr_en;
  logic             redirect, imem_busy, dmem_busy, wb_halt;
  logic             pc_en, if_id_en, if_id_flush, hazard_stall_n, mem_stall_n;
  logic             take_new_PC, ex_fwd_Rs, ex_fwd_Rt, mem_fwd_Rs, mem_fwd_Rt;
  logic             halted;
  logic [2:0]       state;
  logic [CNT_W-1:0] stall_cnt;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_item_t;

  sb_item_t sb[$];

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rs_used     (id_rs_used),
    .id_rt_used     (id_rt_used),
    .ex_wr_en       (ex_wr_en),
    .ex_wr_reg      (ex_wr_reg),
    .ex_is_load     (ex_is_load),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_reg     (mem_wr_reg),
    .redirect       (redirect),
    .imem_busy      (imem_busy),
    .dmem_busy      (dmem_busy),
    .wb_halt        (wb_halt),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .if_id_flush    (if_id_flush),
    .hazard_stall_n (hazard_stall_n),
    .mem_stall_n    (mem_stall_n),
    .take_new_PC    (take_new_PC),
    .ex_fwd_Rs      (ex_fwd_Rs),
    .ex_fwd_Rt      (ex_fwd_Rt),
    .mem_fwd_Rs     (mem_fwd_Rs),
    .mem_fwd_Rt     (mem_fwd_Rt),
    .halted         (halted),
    .state          (state),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [15:0] v);
    sb_item_t it;
    it.tag = tag;
    it.exp = v;
    sb.push_back(it);
  endtask

  function automatic logic [15:0] observe(input string tag);
    case (tag)
      "pc_en":          return {15'd0, pc_en};
      "if_id_en":       return {15'd0, if_id_en};
      "if_id_flush":    return {15'd0, if_id_flush};
      "hazard_stall_n": return {15'd0, hazard_stall_n};
      "mem_stall_n":    return {15'd0, mem_stall_n};
      "take_new_PC":    return {15'd0, take_new_PC};
      "ex_fwd_Rs":      return {15'd0, ex_fwd_Rs};
      "ex_fwd_Rt":      return {15'd0, ex_fwd_Rt};
      "mem_fwd_Rs":     return {15'd0, mem_fwd_Rs};
      "mem_fwd_Rt":     return {15'd0, mem_fwd_Rt};
      "halted":         return {15'd0, halted};
      "state":          return {13'd0, state};
      "stall_cnt":      return {{(16-CNT_W){1'b0}}, stall_cnt};
      default:          return 16'hxxxx;
    endcase
  endfunction

  // Settle, then pop and compare everything queued for this point in time.
  task automatic check();
    sb_item_t    it;
    logic [15:0] obs;
    #1;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      obs = observe(it.tag);
      compared++;
      assert (obs === it.exp)
      else begin
        mismatched++;
        $error("FAIL %s observed=%0h expected=%0h at t=%0t", it.tag, obs, it.exp, $time);
      end
    end
  endtask

  task automatic clear_inputs();
    id_rs = 3'd0; id_rt = 3'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    ex_wr_en = 1'b0; ex_wr_reg = 3'd0; ex_is_load = 1'b0;
    mem_wr_en = 1'b0; mem_wr_reg = 3'd0;
    redirect = 1'b0; imem_busy = 1'b0; wb_halt = 1'b0;
  endtask

  initial begin
    clear_inputs();
    dmem_busy = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset values while dmem is busy.
    expect_val("state", 0); expect_val("stall_cnt", 0); expect_val("mem_stall_n", 1);
    expect_val("pc_en", 1); expect_val("if_id_en", 1); expect_val("halted", 0);
    expect_val("take_new_PC", 0); expect_val("hazard_stall_n", 1);
    check();
    tick();
    rst_n = 1'b1;
    expect_val("mem_stall_n", 0); expect_val("pc_en", 0);
    check();
    tick();
    expect_val("state", 2); expect_val("stall_cnt", 1); expect_val("mem_stall_n", 0);
    check();

    // Asynchronous reset mid-wait, away from any clock edge.
    #1 rst_n = 1'b0;
    expect_val("state", 0); expect_val("stall_cnt", 0); expect_val("mem_stall_n", 1);
    expect_val("pc_en", 1);
    check();
    dmem_busy = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // EX forwarding beats MEM forwarding.
    ex_wr_en = 1'b1; ex_wr_reg = 3'd3; id_rs = 3'd3; id_rs_used = 1'b1;
    mem_wr_en = 1'b1; mem_wr_reg = 3'd3;
    expect_val("ex_fwd_Rs", 1); expect_val("mem_fwd_Rs", 0); expect_val("ex_fwd_Rt", 0);
    expect_val("pc_en", 1); expect_val("hazard_stall_n", 1);
    check();

    // Rt from MEM, no Rs match.
    id_rs = 3'd1; id_rt = 3'd3; id_rt_used = 1'b1; ex_wr_reg = 3'd5;
    expect_val("ex_fwd_Rt", 0); expect_val("mem_fwd_Rt", 1);
    expect_val("ex_fwd_Rs", 0); expect_val("mem_fwd_Rs", 0);
    check();
    tick();

    // Load-use: one stall cycle, then resolved through MEM forwarding.
    clear_inputs();
    ex_wr_en = 1'b1; ex_wr_reg = 3'd3; ex_is_load = 1'b1; id_rs = 3'd3; id_rs_used = 1'b1;
    expect_val("pc_en", 0); expect_val("if_id_en", 0); expect_val("hazard_stall_n", 0);
    expect_val("ex_fwd_Rs", 0); expect_val("stall_cnt", 0);
    check();
    tick();
    ex_wr_en = 1'b0; ex_is_load = 1'b0; mem_wr_en = 1'b1; mem_wr_reg = 3'd3;
    expect_val("state", 1); expect_val("mem_fwd_Rs", 1); expect_val("pc_en", 1);
    expect_val("hazard_stall_n", 1); expect_val("stall_cnt", 1);
    check();
    clear_inputs();

    // Data-memory wait of 4 cycles.
    dmem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_val("mem_stall_n", 0); expect_val("pc_en", 0); expect_val("if_id_en", 0);
      check();
      tick();
      expect_val("state", 2);
      check();
    end
    dmem_busy = 1'b0;
    expect_val("mem_stall_n", 1); expect_val("stall_cnt", 5); expect_val("pc_en", 1);
    check();
    tick();

    // Instruction-memory wait with a redirect arriving mid-wait.
    imem_busy = 1'b1;
    expect_val("take_new_PC", 0); expect_val("pc_en", 0); expect_val("if_id_flush", 1);
    check();
    tick();
    redirect = 1'b1;
    expect_val("take_new_PC", 0); expect_val("hazard_stall_n", 1); expect_val("state", 3);
    check();
    tick();
    redirect = 1'b0;
    expect_val("take_new_PC", 0); expect_val("state", 3);
    check();
    tick();
    imem_busy = 1'b0;
    expect_val("take_new_PC", 1); expect_val("if_id_flush", 1); expect_val("hazard_stall_n", 0);
    check();
    tick();
    expect_val("take_new_PC", 0); expect_val("state", 0); expect_val("stall_cnt", 8);
    check();

    // Halt arriving while dmem is busy waits for the access to finish.
    wb_halt = 1'b1; dmem_busy = 1'b1;
    expect_val("mem_stall_n", 0);
    check();
    tick();
    expect_val("state", 2); expect_val("halted", 0);
    check();
    dmem_busy = 1'b0;
    tick();
    wb_halt = 1'b0;
    for (int i = 0; i < 12; i++) begin
      expect_val("halted", 1); expect_val("pc_en", 0); expect_val("stall_cnt", 9);
      expect_val("mem_stall_n", 1); expect_val("hazard_stall_n", 0); expect_val("state", 4);
      check();
      tick();
    end

    // Reset out of HALTED, then saturate the counter.
    #1 rst_n = 1'b0;
    expect_val("halted", 0); expect_val("state", 0); expect_val("stall_cnt", 0);
    check();
    tick();
    rst_n = 1'b1;
    dmem_busy = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 10 || i >= 15) begin
        expect_val("stall_cnt", (i < 15) ? 16'(i) : 16'd15);
        check();
      end
    end
    dmem_busy = 1'b0;
    tick();
    expect_val("stall_cnt", 15); expect_val("state", 0);
    check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
